// File: rtl/mem_data_interface_if.sv
// Bus-side and memory-side signal bundle of the Mini SRC memory data stage.
// The slave modport is the stage itself; the master modport is the CPU/memory environment.
interface mem_data_interface_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);
  logic [DATA_WIDTH-1:0] bus_in;
  logic                  mar_in;
  logic                  mdr_in;
  logic                  read;
  logic                  write;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [DATA_WIDTH-1:0] mdr_out;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport slave (
    input  bus_in, mar_in, mdr_in, read, write, mem_ready, mem_rdata,
    output mem_addr, mem_wdata, mem_rd, mem_wr, mdr_out, busy, done, err
  );

  modport master (
    output bus_in, mar_in, mdr_in, read, write, mem_ready, mem_rdata,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, mdr_out, busy, done, err
  );
endinterface

// File: rtl/mem_data_interface.sv
// MAR/MDR holder and single-word memory handshake FSM for the Mini SRC datapath.
// Optional access abort after TIMEOUT_CYCLES wait cycles is enabled with `define MEM_TIMEOUT_EN.
module mem_data_interface #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 9,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic                  clock,
  input logic                  clear,
  mem_data_interface_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] mar;
  logic [ADDR_WIDTH-1:0] mar_next;
  logic [DATA_WIDTH-1:0] mdr;
  logic [DATA_WIDTH-1:0] mdr_next;
  logic                  err_q;
  logic                  err_next;
  logic                  rd_q;
  logic                  wr_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  timeout_hit;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Wait-cycle counter: zero outside an access, counts cycles without mem_ready.
  always_ff @(posedge clock) begin
    if (clear) begin
      wait_cnt <= '0;
    end else if ((state != READ) && (state != WRITE)) begin
      wait_cnt <= '0;
    end else if (!bus.mem_ready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state, MAR/MDR load and error decode.
  always_comb begin
    state_next = state;
    mar_next   = mar;
    mdr_next   = mdr;
    err_next   = err_q;
    case (state)
      IDLE: begin
        if (bus.mar_in) mar_next = bus.bus_in[ADDR_WIDTH-1:0];
        else            mar_next = mar;
        if (bus.mdr_in) mdr_next = bus.bus_in;
        else            mdr_next = mdr;
        // Simultaneous read and write is treated as no command.
        if (bus.read && !bus.write) begin
          state_next = READ;
          err_next   = 1'b0;
        end else if (bus.write && !bus.read) begin
          state_next = WRITE;
          err_next   = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      READ: begin
        if (bus.mem_ready) begin
          mdr_next   = bus.mem_rdata;
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next = DONE;
          err_next   = 1'b1;
        end else begin
          state_next = READ;
        end
      end
      WRITE: begin
        if (bus.mem_ready) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next = DONE;
          err_next   = 1'b1;
        end else begin
          state_next = WRITE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, data registers and registered strobes/status.
  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= IDLE;
      mar    <= '0;
      mdr    <= '0;
      err_q  <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      mar    <= mar_next;
      mdr    <= mdr_next;
      err_q  <= err_next;
      rd_q   <= (state_next == READ);
      wr_q   <= (state_next == WRITE);
      busy_q <= (state_next == READ) || (state_next == WRITE);
      done_q <= (state_next == DONE);
    end
  end

  assign bus.mem_addr  = mar;
  assign bus.mem_wdata = mdr;
  assign bus.mdr_out   = mdr;
  assign bus.mem_rd    = rd_q;
  assign bus.mem_wr    = wr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: doc/mem_data_interface.md
Name: mem_data_interface

Overview:
- Memory-side stage of the Mini SRC datapath, directly upstream of the 32-bit 2:1 MDR input mux.
- Holds MAR and MDR.
- Runs single-word read/write handshakes to the memory array.
- Supplies the MDR contents either from the bus (mux input 0) or from memory read data (mux input 1) under FSM control.

Parameters:
DATA_WIDTH, 32, width of bus, MDR and memory data
ADDR_WIDTH, 9, MAR/memory address width (512 words)
TIMEOUT_CYCLES, 15, wait cycles before abort (used only with optional feature)

Ports:
clock  input  1  system clock, all state updates on rising edge
clear  input  1  synchronous, active-high reset
bus_in  input  DATA_WIDTH  BusMuxOut value
mar_in  input  1  load MAR from bus_in[ADDR_WIDTH-1:0]
mdr_in  input  1  load MDR from bus_in
read  input  1  start memory read
write  input  1  start memory write
mem_ready  input  1  memory completes current access this cycle
mem_rdata  input  DATA_WIDTH  memory read data, valid when mem_ready
mem_addr  output  ADDR_WIDTH  always equals MAR
mem_wdata  output  DATA_WIDTH  always equals MDR
mem_rd  output  1  read strobe
mem_wr  output  1  write strobe
mdr_out  output  DATA_WIDTH  MDR contents to bus
busy  output  1  transaction in progress
done  output  1  one-cycle completion pulse
err  output  1  access aborted (tied 0 without optional feature)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high: clear sampled on rising clock edge.
- FSM states:
  - IDLE, READ, WRITE, DONE.
  - All outputs are decoded from registered state/registers; no combinational path from inputs to outputs.
- Reset: state=IDLE; MAR=0, MDR=0, mem_rd=0, mem_wr=0, busy=0, done=0, err=0.
- IDLE:
  - mar_in loads MAR; mdr_in loads MDR (mux select 0 path). Both may load in the same cycle.
  - read=1, write=0 -> READ.
  - write=1, read=0 -> WRITE.
  - read=1 and write=1 -> ignored, stay IDLE, no strobe.
  - Loads and a read/write start may coincide: MAR/MDR update on the same edge the FSM leaves IDLE, and the access uses the new values.
- READ:
  - mem_rd=1, busy=1.
  - mem_ready=1 -> MDR<=mem_rdata (mux select 1 path), go DONE.
  - Otherwise stay in READ.
- WRITE:
  - mem_wr=1, busy=1, mem_wdata=MDR.
  - mem_ready=1 -> go DONE; MDR unchanged.
- DONE:
  - done=1, busy=0, strobes 0, for exactly one cycle; then IDLE.
  - read/write/mar_in/mdr_in sampled in DONE are ignored.
- While busy: mar_in, mdr_in, read, write are ignored; MAR and MDR stay stable for the whole access.
- mem_ready outside READ/WRITE is ignored.
- Latency:
  - read sampled at edge k; mem_rd high during cycle k..k+1.
  - If mem_ready is high in that cycle, MDR is updated at edge k+1 and done is high in cycle k+1..k+2.
  - Each extra wait cycle adds one cycle to this.
- Clear mid-transaction: at that edge state->IDLE and MAR/MDR->0; strobes drop in the following cycle; no done pulse.
- No arithmetic on data; the address is truncated from bus_in low bits; upper bus bits are ignored.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to READ/WRITE and increments every cycle without mem_ready.
  - When the count reaches TIMEOUT_CYCLES, the access aborts: go DONE with err=1; MDR is unchanged on an aborted read.
  - err is sticky until clear or the next accepted read/write.
  - mem_ready arriving on the abort cycle takes priority: normal completion, err=0.
- Undefined: no counter; READ/WRITE wait indefinitely; err is constant 0.

Test Plan:
- Read, zero-wait:
  - Stimulus: clear; bus_in=0x00000055 with mar_in; read; mem_ready=1 with mem_rdata=0x000000F0 in the first READ cycle.
  - Response: mem_addr=0x055; mem_rd high 1 cycle; mdr_out=0x000000F0; done single pulse 2 cycles after read.
- Write with waits:
  - Stimulus: bus_in=0x0000000F with mdr_in; write; mem_ready after 3 low cycles.
  - Response: mem_wr high exactly 4 cycles; mem_wdata=0x0000000F throughout; one done pulse; mdr_out stays 0x0000000F.
- Conflicting/ignored commands:
  - Stimulus: read=write=1 in IDLE. Response: no strobe, busy=0.
  - Stimulus: mar_in with bus_in=0x1FF during READ. Response: mem_addr unchanged.
  - Stimulus: read asserted during the DONE cycle. Response: ignored.
- Clear mid-access:
  - Stimulus: clear on the 2nd READ wait cycle.
  - Response: next cycle mem_rd=0, busy=0, mdr_out=0, mem_addr=0, no done.
- Timeout (TIMEOUT_CYCLES=15, mem_ready held 0):
  - With MEM_TIMEOUT_EN: mem_rd high 15 cycles; then done=1 with err=1; MDR unchanged; err cleared by next read.
  - Without MEM_TIMEOUT_EN: busy still 1 after 100 cycles; err=0.
- Back-to-back:
  - Stimulus: write 0xF then read from the same address, memory model echoes the written value.
  - Response: mdr_out=0x0000000F; two separate done pulses.
